// File: rtl/fc_vector_ram.sv
// rtl/fc_vector_ram.sv - word-addressed RAM with a pointer/direct write port and a multi-lane vector fetch
// A fetch reads LANES words per beat into a registered stage, then packs them into data_out one edge later.
module fc_vector_ram #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 14,
   parameter int VEC_LEN = 120,
   parameter int LANES   = 8,
   parameter int LEN_W   = $clog2(VEC_LEN + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic                      wr_auto,
   input  logic                      wr_ptr_load,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [ADDR_W-1:0]         wr_ptr,
   input  logic                      rd_start,
   input  logic [ADDR_W-1:0]         rd_addr,
   input  logic [LEN_W-1:0]          rd_len,
   input  logic                      rd_ready,
   output logic                      rd_busy,
   output logic                      rd_valid,
   output logic [VEC_LEN*DATA_W-1:0] data_out
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int NBEATS = (VEC_LEN + LANES - 1) / LANES;
   localparam int BEAT_W = $clog2(NBEATS + 1);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t                    r_state;
   logic [ADDR_W-1:0]         r_wr_ptr;
   logic [ADDR_W-1:0]         r_base;
   logic [LEN_W-1:0]          r_len;
   logic [BEAT_W-1:0]         r_beat;
   logic [BEAT_W-1:0]         r_cap_beat;
   logic                      r_cap_en;
   logic                      r_rd_valid;
   logic                      r_rd_busy;
   logic [VEC_LEN*DATA_W-1:0] r_data_out;
   logic [DATA_W-1:0]         r_mem [DEPTH];
   logic [DATA_W-1:0]         r_q   [LANES];

   logic [ADDR_W-1:0]         w_wr_addr;
   logic [ADDR_W-1:0]         w_rd_addr [LANES];
   logic [LEN_W-1:0]          w_len_clamp;
   logic                      w_last;

   // A pointer load in the same cycle as an auto write redirects that write to wr_addr.
   always_comb begin
      w_wr_addr = wr_addr;
      if (wr_auto && !wr_ptr_load) begin
         w_wr_addr = r_wr_ptr;
      end
   end

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_rd_addr[j] = r_base + ADDR_W'(r_beat) * ADDR_W'(LANES) + ADDR_W'(j);
      end
   end

   assign w_len_clamp = (int'(rd_len) > VEC_LEN) ? LEN_W'(VEC_LEN) : rd_len;
   assign w_last      = ((int'(r_beat) + 1) * LANES) >= int'(r_len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
      end else if (wr_en && wr_auto) begin
         r_wr_ptr <= w_wr_addr + ADDR_W'(1);
      end else if (wr_ptr_load) begin
         r_wr_ptr <= wr_addr;
      end
   end

   // Nonblocking write and read at the same edge give a colliding fetch the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[w_wr_addr] <= wr_data;
      end
      if (r_state == FETCH) begin
         for (int j = 0; j < LANES; j++) begin
            r_q[j] <= r_mem[w_rd_addr[j]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_beat     <= '0;
         r_cap_beat <= '0;
         r_cap_en   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_busy  <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_cap_en   <= (r_state == FETCH);
         r_cap_beat <= r_beat;
         for (int i = 0; i < VEC_LEN; i++) begin
            if (r_cap_en && (r_cap_beat == BEAT_W'(i / LANES)) && (LEN_W'(i) < r_len)) begin
               r_data_out[i*DATA_W +: DATA_W] <= r_q[i % LANES];
            end
         end
         case (r_state)
            IDLE: begin
               if (rd_start) begin
                  r_base     <= rd_addr;
                  r_len      <= w_len_clamp;
                  r_beat     <= '0;
                  r_data_out <= '0;
                  r_rd_busy  <= 1'b1;
                  r_state    <= (w_len_clamp == '0) ? HOLD : FETCH;
               end
            end
            FETCH: begin
               r_beat <= r_beat + BEAT_W'(1);
               if (w_last) begin
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               // First HOLD cycle drains the last captured beat before valid rises.
               if (!r_rd_valid) begin
                  r_rd_valid <= 1'b1;
               end else if (rd_ready) begin
                  r_rd_valid <= 1'b0;
                  r_rd_busy  <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign wr_ptr   = r_wr_ptr;
   assign rd_busy  = r_rd_busy;
   assign rd_valid = r_rd_valid;
   assign data_out = r_data_out;

endmodule

// File: tb/tb_fc_vector_ram.sv
// tb/tb_fc_vector_ram.sv - table-driven scoreboard bench for fc_vector_ram
module tb_fc_vector_ram;
   localparam int DW = 16;
   localparam int AW = 14;
   localparam int VL = 120;
   localparam int LN = 8;
   localparam int LW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n = 1'b0;
   logic            wr_en = 1'b0, wr_auto = 1'b0, wr_ptr_load = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [DW-1:0]   wr_data = '0;
   logic [AW-1:0]   wr_ptr;
   logic            rd_start = 1'b0;
   logic [AW-1:0]   rd_addr = '0;
   logic [LW-1:0]   rd_len = '0;
   logic            rd_ready = 1'b0;
   logic            rd_busy, rd_valid;
   logic [VL*DW-1:0] data_out;

   fc_vector_ram #(.DATA_W(DW), .ADDR_W(AW), .VEC_LEN(VL), .LANES(LN), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_auto(wr_auto), .wr_ptr_load(wr_ptr_load),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_ptr(wr_ptr), .rd_start(rd_start),
      .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready), .rd_busy(rd_busy),
      .rd_valid(rd_valid), .data_out(data_out)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      int            lat;
   } rd_vec_t;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [DW-1:0]    m_mem [1<<AW];
   logic [AW-1:0]    m_ptr = '0;
   logic [VL*DW-1:0] exp_q [$];
   logic [VL*DW-1:0] last_vec;
   logic [VL*DW-1:0] held;
   rd_vec_t          tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [VL*DW-1:0] act, input logic [VL*DW-1:0] exp);
      int bad = -1;
      n_tests++;
      for (int i = VL - 1; i >= 0; i--) begin
         if (act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
      end
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s word %0d got %h want %h", name, bad, act[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   function automatic logic [VL*DW-1:0] model_vec(input logic [AW-1:0] a, input logic [LW-1:0] l);
      logic [VL*DW-1:0] v = '0;
      int n = (int'(l) > VL) ? VL : int'(l);
      for (int i = 0; i < n; i++) v[i*DW +: DW] = m_mem[a + AW'(i)];
      return v;
   endfunction

   task automatic wr_direct(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_auto = 1'b0; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      m_mem[a] = d;
   endtask

   task automatic wr_auto_w(input logic [DW-1:0] d);
      wr_en = 1'b1; wr_auto = 1'b1; wr_data = d;
      tick();
      wr_en = 1'b0; wr_auto = 1'b0;
      m_mem[m_ptr] = d;
      m_ptr = m_ptr + AW'(1);
   endtask

   task automatic ptr_load(input logic [AW-1:0] a);
      wr_ptr_load = 1'b1; wr_addr = a;
      tick();
      wr_ptr_load = 1'b0;
      m_ptr = a;
   endtask

   task automatic start_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
      exp_q.push_back(model_vec(a, l));
      rd_addr = a; rd_len = l; rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int exp_edge);
      int e = 0;
      chk({name, "_busy_fetch"}, rd_busy, 1);
      while (!rd_valid && e < 40) begin
         tick();
         e++;
      end
      chk({name, "_latency"}, e, exp_edge);
      last_vec = exp_q.pop_front();
      if (rd_valid) begin
         chk_vec({name, "_data"}, data_out, last_vec);
         chk({name, "_busy_hold"}, rd_busy, 1);
      end
   endtask

   task automatic release_hold(input string name);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk({name, "_valid_after"}, rd_valid, 0);
      chk({name, "_busy_after"}, rd_busy, 0);
      chk_vec({name, "_retain"}, data_out, last_vec);
   endtask

   initial begin
      tbl[0] = '{14'd100,   7'd120, 16};
      tbl[1] = '{14'd0,     7'd10,  3};
      tbl[2] = '{14'd16380, 7'd127, 16};
      tbl[3] = '{14'd0,     7'd0,   1};
      tbl[4] = '{14'd250,   7'd1,   2};
      tbl[5] = '{14'd16383, 7'd9,   3};
      tbl[6] = '{14'd5,     7'd8,   2};

      repeat (3) tick();
      chk("rst_valid", rd_valid, 0);
      chk("rst_busy", rd_busy, 0);
      chk("rst_ptr", wr_ptr, 0);
      chk_vec("rst_data", data_out, '0);
      rst_n = 1'b1;

      for (int a = 0; a < 256; a++) wr_direct(AW'(a), DW'($urandom));
      for (int a = 16256; a < 16384; a++) wr_direct(AW'(a), DW'($urandom));

      ptr_load(14'd100);
      chk("ptr_load", wr_ptr, 100);
      for (int v = 1; v <= 120; v++) wr_auto_w(DW'(v));
      chk("ptr_after_auto", wr_ptr, 220);

      wr_en = 1'b1; wr_auto = 1'b1; wr_ptr_load = 1'b1; wr_addr = 14'd250; wr_data = 16'hbeef;
      tick();
      wr_en = 1'b0; wr_auto = 1'b0; wr_ptr_load = 1'b0;
      m_mem[250] = 16'hbeef;
      m_ptr = 14'd251;
      chk("ptr_load_auto", wr_ptr, 251);

      ptr_load(14'd16383);
      wr_auto_w(16'h7777);
      chk("ptr_wrap", wr_ptr, 0);

      for (int i = 0; i < 7; i++) begin
         start_read(tbl[i].addr, tbl[i].len);
         wait_valid($sformatf("tbl%0d", i), tbl[i].lat);
         release_hold($sformatf("tbl%0d", i));
         if (i == 2) chk("wrap_word4", data_out[4*DW +: DW], m_mem[0]);
         if (i == 0) chk("auto_word119", data_out[119*DW +: DW], 120);
      end

      start_read(14'd20, 7'd16);
      wait_valid("bp", 3);
      held = data_out;
      for (int c = 0; c < 5; c++) begin
         rd_start = 1'b1; rd_addr = AW'($urandom); rd_len = 7'd5;
         tick();
         chk($sformatf("bp_valid%0d", c), rd_valid, 1);
         chk_vec($sformatf("bp_data%0d", c), data_out, held);
      end
      rd_start = 1'b1; rd_ready = 1'b1; rd_addr = 14'd0; rd_len = 7'd8;
      tick();
      rd_start = 1'b0; rd_ready = 1'b0;
      chk("exit_drop_busy", rd_busy, 0);
      tick();
      chk("exit_drop_busy2", rd_busy, 0);
      chk_vec("exit_retain", data_out, held);

      start_read(14'd40, 7'd8);
      wr_direct(14'd40, 16'h1234);
      wait_valid("collide", 1);
      release_hold("collide");
      start_read(14'd40, 7'd8);
      wait_valid("after_collide", 2);
      chk("after_collide_w0", data_out[DW-1:0], 16'h1234);
      release_hold("after_collide");

      start_read(14'd100, 7'd120);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", rd_valid, 0);
      chk("midrst_busy", rd_busy, 0);
      chk("midrst_ptr", wr_ptr, 0);
      chk_vec("midrst_data", data_out, '0);
      void'(exp_q.pop_back());
      m_ptr = '0;
      tick();
      rst_n = 1'b1;
      start_read(14'd100, 7'd120);
      wait_valid("post_rst", 16);
      release_hold("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
